// File: rtl/pattern_detector_param_if.sv
// Serial input, pattern configuration and detect outputs of pattern_detector_param.
// master drives the serial stream and configuration; slave is the detector.
interface pattern_detector_param_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
);
    logic               in;
    logic               in_valid;
    logic               load;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               DETECT;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output in, in_valid, load, pat, pat_len, overlap,
        input  DETECT, match_count
    );

    modport slave (
        input  in, in_valid, load, pat, pat_len, overlap,
        output DETECT, match_count
    );
endinterface

// File: rtl/pattern_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control.
// Define PATTERN_DETECTOR_COUNT_EN to build the saturating match counter.
module pattern_detector_param #(
    parameter int unsigned          MAX_LEN = 8,
    parameter int unsigned          LEN_W   = 4,
    parameter logic [MAX_LEN-1:0]   DEF_PAT = MAX_LEN'(8'b0000_0101),
    parameter int unsigned          DEF_LEN = 4,
    parameter int unsigned          CNT_W   = 8
) (
    input logic                       clk,
    input logic                       reset,
    pattern_detector_param_if.slave   bus
);
    localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, hist_next;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_next;
    logic               detect_q, detect_d;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign hist_next = {hist_q[MAX_LEN-2:0], bus.in};
    assign fill_next = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;

    // Match is judged on the post-shift window so DETECT follows the completing bit.
    assign match = bus.in_valid && !bus.load && (len_q != '0) &&
                   (int'(fill_next) >= int'(len_q)) &&
                   (((hist_next ^ pat_q) & len_mask) == '0);

    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        detect_d = 1'b0;
        if (bus.load) begin
            pat_d  = bus.pat;
            len_d  = (bus.pat_len > LEN_MAX) ? LEN_MAX : bus.pat_len;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            hist_d   = hist_next;
            fill_d   = (match && !bus.overlap) ? '0 : fill_next;
            detect_d = match;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q    <= DEF_PAT;
            len_q    <= LEN_W'(DEF_LEN);
            hist_q   <= '0;
            fill_q   <= '0;
            detect_q <= 1'b0;
        end else begin
            pat_q    <= pat_d;
            len_q    <= len_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            detect_q <= detect_d;
        end
    end

    assign bus.DETECT = detect_q;

`ifdef PATTERN_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.match_count = count_q;
`else
    assign bus.match_count = '0;
`endif
endmodule
